// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC quadrant fix-up block: quadrant codes,
// default sample width and the saturating negation helper.
package cordic_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // sat_neg works on a wide container so one function serves every WIDTH
    // up to SAT_MAX_W; callers sign-extend into it and truncate the result.
    localparam int SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    // Negate a w-bit two's-complement value held sign-extended in x.
    // Returns {overflow, result}; -2^(w-1) clamps to 2^(w-1)-1.
    function automatic logic [SAT_MAX_W:0] sat_neg(
        input logic signed [SAT_MAX_W-1:0] x,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        logic                        ovf;
        max_v = (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
        min_v = ~max_v;
        ovf   = (x == min_v);
        return {ovf, (ovf ? max_v : -x)};
    endfunction

endpackage

// File: rtl/cordic_quadrant_fixup_if.sv
// Streaming interface of the quadrant fix-up block: input sample channel,
// output sample channel and the saturation statistics sideband.
interface cordic_quadrant_fixup_if
    import cordic_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int FLIP_W = 3,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) ();

    logic              in_valid;
    logic              in_ready;
    logic [FLIP_W-1:0] flip;
    logic [WIDTH-1:0]  cos_in;
    logic [WIDTH-1:0]  sin_in;
    logic [TAG_W-1:0]  tag_in;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  cos_out;
    logic [WIDTH-1:0]  sin_out;
    logic [TAG_W-1:0]  tag_out;
    logic              sat_flag;

    logic [CNT_W-1:0]  sat_count;
    logic              sat_clear;

    modport slave (
        input  in_valid, flip, cos_in, sin_in, tag_in, out_ready, sat_clear,
        output in_ready, out_valid, cos_out, sin_out, tag_out, sat_flag, sat_count
    );

    modport master (
        output in_valid, flip, cos_in, sin_in, tag_in, out_ready, sat_clear,
        input  in_ready, out_valid, cos_out, sin_out, tag_out, sat_flag, sat_count
    );

endinterface

// File: rtl/cordic_pipe_stage.sv
// Generic valid/ready register slice. Accepts when empty or when the held
// word leaves in the same cycle, so a chain of slices runs at full rate.
module cordic_pipe_stage #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Load a new word whenever the slot is free; data only moves on a real transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/cordic_quadrant_fixup.sv
// Maps the raw CORDIC cos/sin pair back to the original angle by rotating
// through k quarter turns. S1 captures the raw sample, S2 holds the mapped
// result; saturation events on negation are flagged and counted.
module cordic_quadrant_fixup
    import cordic_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int FLIP_W = 3,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cordic_quadrant_fixup_if.slave bus
);

    localparam int S1_W = 2 + 2 * WIDTH + TAG_W;
    localparam int S2_W = 1 + 2 * WIDTH + TAG_W;

    logic                    s1_valid;
    logic                    s1_adv;
    logic                    s2_valid;
    logic [S1_W-1:0]         s1_din;
    logic [S1_W-1:0]         s1_q;
    logic [S2_W-1:0]         s2_din;
    logic [S2_W-1:0]         s2_q;

    quad_t                   q;
    logic signed [WIDTH-1:0] c_raw;
    logic signed [WIDTH-1:0] s_raw;
    logic [TAG_W-1:0]        tag_s1;
    logic [SAT_MAX_W:0]      neg_c;
    logic [SAT_MAX_W:0]      neg_s;
    logic signed [WIDTH-1:0] cos_map;
    logic signed [WIDTH-1:0] sin_map;
    logic [1:0]              n_events;
    logic [CNT_W:0]          cnt_sum;
    logic [CNT_W-1:0]        sat_count_r;
    logic                    unused_bits;

    // Only k mod 4 matters, so S1 keeps just the two low bits of flip.
    assign s1_din = {bus.flip[1:0], bus.cos_in, bus.sin_in, bus.tag_in};

    cordic_pipe_stage #(.N(S1_W)) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (s1_din),
        .out_valid (s1_valid),
        .out_ready (s1_adv),
        .out_data  (s1_q)
    );

    assign q      = quad_t'(s1_q[S1_W-1 -: 2]);
    assign c_raw  = s1_q[TAG_W + WIDTH +: WIDTH];
    assign s_raw  = s1_q[TAG_W +: WIDTH];
    assign tag_s1 = s1_q[TAG_W-1:0];

    // Quarter-turn rotation with saturating negation and per-sample event count.
    always_comb begin
        neg_c    = sat_neg(SAT_MAX_W'(c_raw), WIDTH);
        neg_s    = sat_neg(SAT_MAX_W'(s_raw), WIDTH);
        cos_map  = c_raw;
        sin_map  = s_raw;
        n_events = 2'd0;
        case (q)
            Q0: begin
                cos_map  = c_raw;
                sin_map  = s_raw;
                n_events = 2'd0;
            end
            Q1: begin
                cos_map  = neg_s[WIDTH-1:0];
                sin_map  = c_raw;
                n_events = {1'b0, neg_s[SAT_MAX_W]};
            end
            Q2: begin
                cos_map  = neg_c[WIDTH-1:0];
                sin_map  = neg_s[WIDTH-1:0];
                n_events = {1'b0, neg_c[SAT_MAX_W]} + {1'b0, neg_s[SAT_MAX_W]};
            end
            Q3: begin
                cos_map  = s_raw;
                sin_map  = neg_c[WIDTH-1:0];
                n_events = {1'b0, neg_c[SAT_MAX_W]};
            end
            default: begin
                cos_map  = c_raw;
                sin_map  = s_raw;
                n_events = 2'd0;
            end
        endcase
    end

    assign s2_din = {(n_events != 2'd0), tag_s1, cos_map, sin_map};

    cordic_pipe_stage #(.N(S2_W)) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s1_adv),
        .in_data   (s2_din),
        .out_valid (s2_valid),
        .out_ready (bus.out_ready),
        .out_data  (s2_q)
    );

    assign bus.out_valid = s2_valid;
    assign {bus.sat_flag, bus.tag_out, bus.cos_out, bus.sin_out} = s2_q;

    assign cnt_sum = {1'b0, sat_count_r} + (CNT_W + 1)'(n_events);

    // Events are counted as the sample enters S2; clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_r <= '0;
        end else if (bus.sat_clear) begin
            sat_count_r <= '0;
        end else if (s1_valid && s1_adv) begin
            sat_count_r <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

    assign bus.sat_count = sat_count_r;

    // Upper bits of the wide negation results and of flip carry no information.
    assign unused_bits = ^{neg_c[SAT_MAX_W-1:WIDTH], neg_s[SAT_MAX_W-1:WIDTH], bus.flip};

endmodule

// File: tb/tb_cordic_quadrant_fixup.sv
// Self-checking bench for cordic_quadrant_fixup: directed quadrant and
// saturation cases, backpressure, throughput, random traffic against a
// behavioural rotation model, counter saturation and mid-stream reset.
module tb_cordic_quadrant_fixup;

    localparam int W    = 16;
    localparam int FW   = 3;
    localparam int TW   = 4;
    localparam int MAXV = 32767;

    typedef struct packed {
        logic [W-1:0]  c;
        logic [W-1:0]  s;
        logic [TW-1:0] tag;
        logic          flag;
    } obs_t;

    typedef struct {
        int c;
        int s;
        int ev;
    } ref_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_quadrant_fixup_if #(.WIDTH(W), .FLIP_W(FW), .TAG_W(TW), .CNT_W(16)) bus ();
    cordic_quadrant_fixup_if #(.WIDTH(W), .FLIP_W(FW), .TAG_W(TW), .CNT_W(4))  bus4 ();

    cordic_quadrant_fixup #(.WIDTH(W), .FLIP_W(FW), .TAG_W(TW), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cordic_quadrant_fixup #(.WIDTH(W), .FLIP_W(FW), .TAG_W(TW), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int   n_pass  = 0;
    int   n_total = 0;
    int   exp_cnt = 0;
    bit   acc;
    obs_t exp_q[$];
    obs_t got_q[$];

    // Rotation of (c, s) by k quarter turns, with negation clamped to +MAXV.
    function automatic ref_t ref_rot(int k, int c, int s);
        ref_t r;
        int   quad;
        int   nc;
        int   ns;
        int   sc;
        int   ss;
        quad = ((k % 4) + 4) % 4;
        nc = -c;
        ns = -s;
        sc = (nc > MAXV) ? 1 : 0;
        ss = (ns > MAXV) ? 1 : 0;
        if (sc != 0) nc = MAXV;
        if (ss != 0) ns = MAXV;
        case (quad)
            0:       r = '{c, s, 0};
            1:       r = '{ns, c, ss};
            2:       r = '{nc, ns, sc + ss};
            default: r = '{s, nc, sc};
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        if ($urandom_range(0, 3) == 0) return 16'h8000;
        return 16'($urandom);
    endfunction

    // One clock of the main DUT: records transfers due at the coming edge.
    task automatic tick();
        ref_t r;
        obs_t e;
        #1;
        acc = 1'b0;
        if (bus.in_valid && bus.in_ready) begin
            r = ref_rot(int'($signed(bus.flip)), int'($signed(bus.cos_in)), int'($signed(bus.sin_in)));
            e.c    = W'(r.c);
            e.s    = W'(r.s);
            e.tag  = bus.tag_in;
            e.flag = (r.ev != 0);
            exp_q.push_back(e);
            exp_cnt = (exp_cnt + r.ev > 65535) ? 65535 : exp_cnt + r.ev;
            acc = 1'b1;
        end
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(obs_t'({bus.cos_out, bus.sin_out, bus.tag_out, bus.sat_flag}));
        end
        @(negedge clk);
    endtask

    task automatic drain(output bit ok);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (got_q.size() == exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic set_sample(logic [FW-1:0] k, logic [W-1:0] c, logic [W-1:0] s, logic [TW-1:0] t);
        bus.flip   = k;
        bus.cos_in = c;
        bus.sin_in = s;
        bus.tag_in = t;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.out_ready = 1; bus.sat_clear = 0;
        set_sample('0, '0, '0, '0);
        bus4.in_valid = 0; bus4.out_ready = 1; bus4.sat_clear = 0;
        bus4.flip = '0; bus4.cos_in = '0; bus4.sin_in = '0; bus4.tag_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
        n_total++; if ({bus.cos_out, bus.sin_out, bus.tag_out, bus.sat_flag} !== '0)
            $display("FAIL rst_outputs got=%h/%h/%h/%b exp=0", bus.cos_out, bus.sin_out, bus.tag_out, bus.sat_flag); else n_pass++;
        n_total++; if (bus.sat_count !== 16'd0) $display("FAIL rst_sat_count got=%0d exp=0", bus.sat_count); else n_pass++;
        n_total++; if (bus4.sat_count !== 4'd0) $display("FAIL rst_sat_count4 got=%0d exp=0", bus4.sat_count); else n_pass++;
    endtask

    // Directed table: {flip, cos_in, sin_in, exp_cos, exp_sin, exp_flag, exp_count}.
    task automatic run_directed(string name, logic [FW-1:0] k, logic [W-1:0] c, logic [W-1:0] s,
                                logic [W-1:0] ec, logic [W-1:0] es, logic ef, int ecnt);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        set_sample(k, c, s, 4'hA);
        tick();
        n_total++; if (acc !== 1'b1) $display("FAIL %s_accept got=%b exp=1", name, acc); else n_pass++;
        bus.in_valid = 1'b0;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL %s_early got=%b exp=0", name, bus.out_valid); else n_pass++;
        tick();
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL %s_latency got=%b exp=1", name, bus.out_valid); else n_pass++;
        n_total++; if ({bus.cos_out, bus.sin_out, bus.sat_flag} !== {ec, es, ef})
            $display("FAIL %s_data got=%h/%h/%b exp=%h/%h/%b", name, bus.cos_out, bus.sin_out, bus.sat_flag, ec, es, ef);
        else n_pass++;
        n_total++; if (int'(bus.sat_count) != ecnt) $display("FAIL %s_count got=%0d exp=%0d", name, bus.sat_count, ecnt); else n_pass++;
        tick();
    endtask

    task automatic test_quadrant();
        run_directed("q_k+1", 3'b001, 16'h4000, 16'h1000, 16'hF000, 16'h4000, 1'b0, 0);
        run_directed("q_k-1", 3'b111, 16'h4000, 16'h1000, 16'h1000, 16'hC000, 1'b0, 0);
        run_directed("q_k-2", 3'b110, 16'h4000, 16'h1000, 16'hC000, 16'hF000, 1'b0, 0);
        run_directed("q_k0",  3'b000, 16'h4000, 16'h1000, 16'h4000, 16'h1000, 1'b0, 0);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        run_directed("sat_k2",  3'b010, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b1, 2);
        run_directed("sat_k0",  3'b000, 16'h8000, 16'h1234, 16'h8000, 16'h1234, 1'b0, 2);
        run_directed("sat_k1",  3'b001, 16'h0005, 16'h8000, 16'h7FFF, 16'h0005, 1'b1, 3);
        run_directed("sat_k3",  3'b011, 16'h8000, 16'h0007, 16'h0007, 16'h7FFF, 1'b1, 4);
        run_directed("sat_k-3", 3'b101, 16'h8000, 16'h8000, 16'h7FFF, 16'h8000, 1'b1, 5);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] fl[7];
        logic [W-1:0]  cv[7];
        logic [W-1:0]  sv[7];
        int            idx;
        bit            ok;
        for (int i = 0; i < 7; i++) begin
            fl[i] = FW'($urandom); cv[i] = rnd_val(); sv[i] = rnd_val();
        end
        idx = 1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            set_sample(fl[idx], cv[idx], sv[idx], TW'(idx));
            tick();
            if (acc) idx++;
        end
        n_total++; if (idx - 1 != 2) $display("FAIL bp_accepted got=%0d exp=2", idx - 1); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            n_total++;
            if (obs_t'({bus.cos_out, bus.sin_out, bus.tag_out, bus.sat_flag}) !== exp_q[0])
                $display("FAIL bp_stable[%0d] got=%h exp=%h", j,
                         obs_t'({bus.cos_out, bus.sin_out, bus.tag_out, bus.sat_flag}), exp_q[0]);
            else n_pass++;
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && idx <= 5; i++) begin
            bus.in_valid = 1'b1;
            set_sample(fl[idx], cv[idx], sv[idx], TW'(idx));
            tick();
            if (acc) idx++;
        end
        drain(ok);
        n_total++; if (!ok) $display("FAIL bp_drain got=timeout exp=drained"); else n_pass++;
        n_total++; if (got_q.size() != 5 || exp_q.size() != 5)
            $display("FAIL bp_count got=%0d exp=5 (model %0d)", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i] || int'(got_q[i].tag) != i + 1)
                $display("FAIL bp_sample[%0d] got=%h exp=%h tag %0d", i, got_q[i], exp_q[i], i + 1);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_throughput();
        logic [23:0] obs_mask;
        logic [23:0] exp_mask;
        int          n_acc;
        int          s0;
        bit          ok;
        obs_mask = '0; exp_mask = '0; n_acc = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus.in_valid = (i < 20);
            set_sample(FW'($urandom), rnd_val(), rnd_val(), TW'(i));
            s0 = got_q.size();
            tick();
            if (acc) n_acc++;
            obs_mask[i] = (got_q.size() > s0);
            exp_mask[i] = (i >= 2 && i < 22);
        end
        n_total++; if (n_acc != 20) $display("FAIL tp_accepted got=%0d exp=20", n_acc); else n_pass++;
        n_total++; if (obs_mask !== exp_mask) $display("FAIL tp_out_pattern got=%h exp=%h", obs_mask, exp_mask); else n_pass++;
        drain(ok);
        n_total++; if (!ok || got_q.size() != 20) $display("FAIL tp_count got=%0d exp=20", got_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL tp_sample[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            set_sample(FW'($urandom), rnd_val(), rnd_val(), TW'($urandom));
            tick();
        end
        drain(ok);
        n_total++; if (!ok) $display("FAIL rnd_drain got=timeout exp=drained"); else n_pass++;
        n_total++; if (got_q.size() != exp_q.size())
            $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rnd_sample[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++; if (int'(bus.sat_count) != exp_cnt)
            $display("FAIL rnd_sat_count got=%0d exp=%0d", bus.sat_count, exp_cnt); else n_pass++;
        bus.sat_clear = 1'b1;
        tick();
        bus.sat_clear = 1'b0;
        exp_cnt = 0;
        n_total++; if (bus.sat_count !== 16'd0) $display("FAIL rnd_clear got=%0d exp=0", bus.sat_count); else n_pass++;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_counter_edges();
        int ev_total;
        int expv;
        ev_total = 0;
        bus4.out_ready = 1'b1;
        bus4.flip = 3'b010; bus4.cos_in = 16'h8000; bus4.sin_in = 16'h8000;
        for (int n = 1; n <= 9; n++) begin
            bus4.in_valid = 1'b1;
            @(negedge clk);
            ev_total += 2;
            if (n == 7 || n == 9) begin
                bus4.in_valid = 1'b0;
                repeat (2) @(negedge clk);
                expv = (ev_total > 15) ? 15 : ev_total;
                n_total++; if (int'(bus4.sat_count) != expv)
                    $display("FAIL cnt_sat_after_%0d got=%0d exp=%0d", n, bus4.sat_count, expv); else n_pass++;
            end
        end
        bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid  = 1'b0;
        bus4.sat_clear = 1'b1;
        @(negedge clk);
        bus4.sat_clear = 1'b0;
        n_total++; if (bus4.sat_count !== 4'd0) $display("FAIL cnt_clear_vs_inc got=%0d exp=0", bus4.sat_count); else n_pass++;
        n_total++; if ({bus4.out_valid, bus4.sat_flag} !== 2'b11)
            $display("FAIL cnt_clear_flag got=%b%b exp=11", bus4.out_valid, bus4.sat_flag); else n_pass++;
        bus4.in_valid = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (bus4.sat_count !== 4'd2) $display("FAIL cnt_after_clear got=%0d exp=2", bus4.sat_count); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            set_sample(3'b010, 16'h8000, 16'h8000, TW'(i + 7));
            tick();
            if (!bus.in_ready) break;
        end
        n_total++; if ({bus.out_valid, bus.in_ready} !== 2'b10)
            $display("FAIL mid_full got=%b%b exp=10", bus.out_valid, bus.in_ready); else n_pass++;
        n_total++; if (bus.sat_count !== 16'd2) $display("FAIL mid_pre_count got=%0d exp=2", bus.sat_count); else n_pass++;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_total++; if ({bus.out_valid, bus.sat_flag, bus.sat_count} !== '0)
            $display("FAIL mid_rst got=%b/%b/%0d exp=0/0/0", bus.out_valid, bus.sat_flag, bus.sat_count); else n_pass++;
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        n_total++; if ({bus.in_ready, bus.out_valid} !== 2'b10)
            $display("FAIL mid_after_rst got=%b%b exp=10", bus.in_ready, bus.out_valid); else n_pass++;
        got_q.delete(); exp_q.delete();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        n_total++; if (got_q.size() != 0) $display("FAIL mid_stale got=%0d exp=0", got_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_quadrant();
        test_saturation();
        test_backpressure();
        test_throughput();
        test_random();
        test_counter_edges();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cordic_quadrant_fixup.md
Name: cordic_quadrant_fixup

Overview:
- Parametrised, pipelined successor to the combinational CORDIC result converter.
- Takes the raw CORDIC cos/sin pair plus the signed quarter-turn count `flip` from the angle pre-reduction stage. Outputs cos/sin of the original angle.
- Two-stage pipeline with valid/ready handshakes on both sides, saturating negation, a sideband tag and a saturation-event counter.
- Sits between the CORDIC iteration core and the result register/bus interface.

Parameters:
- WIDTH, 16, two's-complement width of cos/sin samples.
- FLIP_W, 3, width of the signed quarter-turn count (must be >= 2).
- TAG_W, 4, width of the sideband tag carried alongside each sample.
- CNT_W, 16, width of the saturation-event counter.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- flip  in  FLIP_W  signed quarter-turn count k.
- cos_in  in  WIDTH  signed raw cosine.
- sin_in  in  WIDTH  signed raw sine.
- tag_in  in  TAG_W  sideband tag.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- cos_out  out  WIDTH  signed corrected cosine.
- sin_out  out  WIDTH  signed corrected sine.
- tag_out  out  TAG_W  tag of the output sample.
- sat_flag  out  1  this output sample had at least one saturated negation.
- sat_count  out  CNT_W  total saturation events since reset/clear.
- sat_clear  in  1  synchronous clear of sat_count.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset state: all outputs are 0, including out_valid, sat_flag and sat_count. in_ready is 1 in the cycle after reset deasserts. Both stage valid bits are cleared.
- Reset mid-operation: in-flight samples are discarded. No partial output.
- Handshake: transfer on in_valid & in_ready, and on out_valid & out_ready.
  - Data/tag must be held stable while out_valid=1 and out_ready=0.
  - in_ready has no combinational path from in_valid.
  - in_ready = !s1_valid | s1_adv.
  - s1_adv = !s2_valid | out_ready.
- Stage 1 (S1): registers flip[1:0], cos_in, sin_in and tag_in on input transfer. Quadrant q = flip[1:0], i.e. k mod 4 in two's complement, so any FLIP_W value is legal.
- Stage 2 (S2): computes and registers the outputs, loaded when s1_adv. Mapping for angle θ + k·90°:
  - q=0: cos=c, sin=s.
  - q=1: cos=-s, sin=c.
  - q=2: cos=-c, sin=-s.
  - q=3: cos=s, sin=-c.
- Saturating negation: negating -2^(WIDTH-1) yields 2^(WIDTH-1)-1. Each saturated component counts as one event, so 0, 1 or 2 events per sample.
- sat_flag: registered with the S2 data. Set iff the sample had ≥1 saturation event.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Full throughput is 1 sample/cycle while out_ready=1.
- Backpressure: S2 holds while out_ready=0. S1 fills, then in_ready drops. No sample is dropped or duplicated.
- sat_count update:
  - Increments by the number of events when the sample is loaded into S2, not at output transfer.
  - Saturates at 2^CNT_W-1; no wrap.
  - sat_clear has priority over a same-cycle increment: result is 0.
  - rst has priority over everything.
- Simultaneous events: input transfer and S1→S2 advance in the same cycle are legal; S1 holds the new sample. Output transfer and S2 load in the same cycle are legal.

Decomposition:
- Shared package (cordic_pkg):
  - Quadrant encoding constants Q0..Q3.
  - Default WIDTH.
  - Function sat_neg(x) returning negated value plus overflow bit.
- Sub-module: cordic_pipe_stage, a generic valid/ready register slice of width N. Instantiated twice (S1 payload, S2 payload).
- Quadrant mapping and sat_neg stay in the top module.

Test Plan (WIDTH=16):
- Quadrant mapping, out_ready=1: k=+1, c=0x4000, s=0x1000 → after 2 cycles cos=0xF000, sin=0x4000, sat_flag=0.
  - k=-1 (3'b111) → cos=0x1000, sin=0xC000.
  - k=-2 (3'b110) → cos=0xC000, sin=0xF000.
- Saturation: k=2, c=0x8000, s=0x8000 → cos=0x7FFF, sin=0x7FFF, sat_flag=1, sat_count 0→2.
  - Then k=0 with c=0x8000 → cos=0x8000 (no negation), count unchanged.
- Backpressure: stream 5 tagged samples (tags 1..5) while out_ready=0 → in_ready drops after 2 accepted.
  - Release out_ready → tags emerge 1..5 in order, none lost or duplicated, data stable while stalled.
- Throughput: continuous in_valid with out_ready=1 for 20 samples → out_valid continuous from cycle 2, one sample per cycle.
- Counter edges: preload by forcing 2^CNT_W-1 events (CNT_W=4 build, 9 double-saturated samples) → sat_count sticks at 15.
  - sat_clear in the same cycle as an event → sat_count=0.
- Reset mid-stream: assert rst with both stages full → next cycle out_valid=0, sat_count=0, in_ready=1 after deassert. No stale sample appears.
